// File: rtl/bus_datapath_pkg.sv
// Shared encodings for the bus datapath: dbus source select and control FSM states.
package bus_datapath_pkg;

  typedef enum logic [1:0] {
    SRC_MEM  = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_REG  = 2'd2,
    SRC_ZERO = 2'd3
  } src_sel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/bus_datapath_if.sv
// Memory request/response bus between the datapath (master) and a memory (slave).
interface bus_datapath_if #(
  parameter int unsigned WIDTH = 8
);

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/bus_alu.sv
// Adder/subtractor on reg0/reg1 with carry-out (carry=1 means no borrow) and reg0 zero detect.
module bus_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0] sum;

  // Subtraction is a + ~b + 1 so the carry-out doubles as a not-borrow flag.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, (subtract ? ~b : b)} + (WIDTH+1)'(subtract);
    result = sum[WIDTH-1:0];
    carry  = sum[WIDTH];
    zero   = (a == '0);
  end

endmodule

// File: rtl/bus_datapath.sv
// Micro-stepped datapath: register file, ir, pc and carry flag fed from a shared dbus,
// with zero-wait steps for internal moves and a one-deep memory access state.
module bus_datapath
  import bus_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 4,
  localparam int unsigned IW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic [1:0]       src_sel,
  input  logic [IW-1:0]    src_idx,
  input  logic             dst_load,
  input  logic [IW-1:0]    dst_idx,
  input  logic             ir_load,
  input  logic             jump,
  input  logic             immediate,
  input  logic             mem_store,
  input  logic             do_subtract,
  input  logic             flag_load,
  bus_datapath_if.master   mem,
  output logic [WIDTH-1:0] ir,
  output logic [WIDTH-1:0] pc,
  output logic             flag_carry,
  output logic             a_is_zero,
  output logic             busy,
  output logic [WIDTH-1:0] dbus
);

  typedef struct packed {
    logic [1:0]       src_sel;
    logic [IW-1:0]    src_idx;
    logic             dst_load;
    logic [IW-1:0]    dst_idx;
    logic             ir_load;
    logic             jump;
    logic             immediate;
    logic             mem_store;
    logic             do_subtract;
    logic             flag_load;
    logic [WIDTH-1:0] addr;
  } ctl_t;

  state_t           state, state_next;
  ctl_t             in_ctl, lat, ctl;
  logic             need_access, commit, latch_ctl;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  // Snapshot of the live control inputs, including the resolved access address.
  always_comb begin
    in_ctl.src_sel     = src_sel;
    in_ctl.src_idx     = src_idx;
    in_ctl.dst_load    = dst_load;
    in_ctl.dst_idx     = dst_idx;
    in_ctl.ir_load     = ir_load;
    in_ctl.jump        = jump;
    in_ctl.immediate   = immediate;
    in_ctl.mem_store   = mem_store;
    in_ctl.do_subtract = do_subtract;
    in_ctl.flag_load   = flag_load;
    in_ctl.addr        = immediate ? pc : regs[NREGS-1];
    need_access        = (src_sel == SRC_MEM) || mem_store;
    ctl                = (state == ACCESS) ? lat : in_ctl;
  end

  // Control state register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state plus commit/latch strobes; steps while busy fall through unused.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    latch_ctl  = 1'b0;
    case (state)
      IDLE: begin
        if (step) begin
          if (need_access) begin
            latch_ctl  = 1'b1;
            state_next = ACCESS;
          end else begin
            commit = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (mem.mem_ready) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  bus_alu #(.WIDTH(WIDTH)) u_alu (
    .a        (regs[0]),
    .b        (regs[1]),
    .subtract (ctl.do_subtract),
    .result   (alu_result),
    .carry    (alu_carry),
    .zero     (a_is_zero)
  );

  // dbus source mux; a store from the memory source drives zero rather than read data.
  always_comb begin
    dbus = '0;
    case (src_sel_t'(ctl.src_sel))
      SRC_MEM:  dbus = ctl.mem_store ? '0 : mem.mem_rdata;
      SRC_ALU:  dbus = alu_result;
      SRC_REG:  dbus = regs[ctl.src_idx];
      SRC_ZERO: dbus = '0;
      default:  dbus = '0;
    endcase
  end

  // Memory bus outputs derive from the state register and latched controls.
  always_comb begin
    busy          = (state == ACCESS);
    mem.mem_req   = busy;
    mem.mem_we    = busy && lat.mem_store;
    mem.mem_addr  = ctl.addr;
    mem.mem_wdata = dbus;
  end

  // Hold controls for the duration of a memory access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          lat <= '0;
    else if (latch_ctl) lat <= in_ctl;
  end

  // Architectural state update on commit; all reads see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      ir         <= '0;
      pc         <= '0;
      flag_carry <= 1'b0;
    end else if (commit) begin
      if (ctl.dst_load)  regs[ctl.dst_idx] <= dbus;
      if (ctl.ir_load)   ir <= dbus;
      if (ctl.jump)           pc <= dbus;
      else if (ctl.immediate) pc <= pc + WIDTH'(1);
      if (ctl.flag_load) flag_carry <= alu_carry;
    end
  end

endmodule

// File: tb/tb_bus_datapath.sv
// Directed bench for bus_datapath: an 8-bit/4-register instance and a 16-bit/8-register instance.
module tb_bus_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        step_a, step_b;
  logic [1:0]  src_sel;
  logic [2:0]  src_idx, dst_idx;
  logic        dst_load, ir_load, jump, immediate, mem_store, do_subtract, flag_load;
  logic [15:0] rdata;
  logic        ready;

  logic [7:0]  ir_a, pc_a, dbus_a;
  logic        flag_a, az_a, busy_a;
  logic [15:0] ir_b, pc_b, dbus_b;
  logic        flag_b, az_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int busy_cnt;
  bit req_held;

  always #5 clk = ~clk;

  bus_datapath_if #(.WIDTH(8))  mem_a ();
  bus_datapath_if #(.WIDTH(16)) mem_b ();

  assign mem_a.mem_rdata = rdata[7:0];
  assign mem_a.mem_ready = ready;
  assign mem_b.mem_rdata = rdata;
  assign mem_b.mem_ready = ready;

  bus_datapath #(.WIDTH(8), .NREGS(4)) dut_a (
    .clk(clk), .reset(reset), .step(step_a), .src_sel(src_sel),
    .src_idx(src_idx[1:0]), .dst_load(dst_load), .dst_idx(dst_idx[1:0]),
    .ir_load(ir_load), .jump(jump), .immediate(immediate), .mem_store(mem_store),
    .do_subtract(do_subtract), .flag_load(flag_load), .mem(mem_a),
    .ir(ir_a), .pc(pc_a), .flag_carry(flag_a), .a_is_zero(az_a), .busy(busy_a), .dbus(dbus_a)
  );

  bus_datapath #(.WIDTH(16), .NREGS(8)) dut_b (
    .clk(clk), .reset(reset), .step(step_b), .src_sel(src_sel),
    .src_idx(src_idx), .dst_load(dst_load), .dst_idx(dst_idx),
    .ir_load(ir_load), .jump(jump), .immediate(immediate), .mem_store(mem_store),
    .do_subtract(do_subtract), .flag_load(flag_load), .mem(mem_b),
    .ir(ir_b), .pc(pc_b), .flag_carry(flag_b), .a_is_zero(az_b), .busy(busy_b), .dbus(dbus_b)
  );

  // Count completed writes on the 8-bit instance.
  always @(posedge clk) begin
    if (mem_a.mem_req && mem_a.mem_we && mem_a.mem_ready) n_writes++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_ctl();
    src_sel = 2'd0; src_idx = 3'd0; dst_idx = 3'd0;
    dst_load = 1'b0; ir_load = 1'b0; jump = 1'b0; immediate = 1'b0;
    mem_store = 1'b0; do_subtract = 1'b0; flag_load = 1'b0;
  endtask

  task automatic pulse(input bit b);
    if (b) step_b = 1'b1;
    else   step_a = 1'b1;
    @(posedge clk); #1;
    step_a = 1'b0;
    step_b = 1'b0;
  endtask

  // Load a register through a one-cycle memory read.
  task automatic load_reg(input bit b, input logic [2:0] idx, input logic [15:0] val);
    clr_ctl();
    src_sel = 2'd0; dst_load = 1'b1; dst_idx = idx;
    pulse(b);
    clr_ctl();
    rdata = val; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    step_a = 1'b0; step_b = 1'b0; ready = 1'b0; rdata = 16'h0;
    clr_ctl();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc",    32'(pc_a), 0);
    check("rst_ir",    32'(ir_a), 0);
    check("rst_busy",  32'(busy_a), 0);
    check("rst_req",   32'(mem_a.mem_req), 0);
    check("rst_we",    32'(mem_a.mem_we), 0);
    check("rst_flag",  32'(flag_a), 0);
    check("rst_azero", 32'(az_a), 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // ALU add with carry: 0xF0 + 0x20
    load_reg(0, 3'd0, 16'hF0);
    load_reg(0, 3'd1, 16'h20);
    clr_ctl();
    src_sel = 2'd1; dst_load = 1'b1; dst_idx = 3'd0; flag_load = 1'b1;
    #1 check("add_dbus", 32'(dbus_a), 'h10);
    pulse(0);
    check("add_req",  32'(mem_a.mem_req), 0);
    check("add_busy", 32'(busy_a), 0);
    check("add_flag", 32'(flag_a), 1);
    clr_ctl();
    src_sel = 2'd2; src_idx = 3'd0;
    #1 check("add_reg0", 32'(dbus_a), 'h10);
    check("add_azero", 32'(az_a), 0);

    // Instruction fetch with three wait cycles
    load_reg(0, 3'd2, 16'h05);
    clr_ctl();
    src_sel = 2'd2; src_idx = 3'd2; jump = 1'b1;
    pulse(0);
    check("jmp_pc5", 32'(pc_a), 'h05);
    clr_ctl();
    src_sel = 2'd0; immediate = 1'b1; ir_load = 1'b1;
    pulse(0);
    clr_ctl();
    check("fetch_addr", 32'(mem_a.mem_addr), 'h05);
    busy_cnt = 0; req_held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (busy_a) busy_cnt++;
      if (!mem_a.mem_req) req_held = 1'b0;
      if (i == 2) begin rdata = 16'hA7; ready = 1'b1; end
      @(posedge clk); #1;
    end
    ready = 1'b0;
    check("fetch_busycnt", 32'(busy_cnt), 3);
    check("fetch_reqheld", 32'(req_held), 1);
    check("fetch_busy",    32'(busy_a), 0);
    check("fetch_req",     32'(mem_a.mem_req), 0);
    check("fetch_ir",      32'(ir_a), 'hA7);
    check("fetch_pc",      32'(pc_a), 'h06);

    // pc wrap on increment, and jump winning over increment
    load_reg(0, 3'd2, 16'hFF);
    clr_ctl();
    src_sel = 2'd2; src_idx = 3'd2; jump = 1'b1;
    pulse(0);
    check("jmp_pcff", 32'(pc_a), 'hFF);
    clr_ctl();
    src_sel = 2'd3; immediate = 1'b1;
    pulse(0);
    check("wrap_pc", 32'(pc_a), 'h00);
    clr_ctl();
    src_sel = 2'd2; src_idx = 3'd2; jump = 1'b1;
    pulse(0);
    load_reg(0, 3'd2, 16'h40);
    clr_ctl();
    src_sel = 2'd2; src_idx = 3'd2; jump = 1'b1; immediate = 1'b1;
    #1 check("jmpinc_dbus", 32'(dbus_a), 'h40);
    pulse(0);
    check("jmpinc_pc", 32'(pc_a), 'h40);

    // Store reg2 at reg3, with a second step while busy
    load_reg(0, 3'd2, 16'h5A);
    load_reg(0, 3'd3, 16'h80);
    clr_ctl();
    src_sel = 2'd2; src_idx = 3'd2; mem_store = 1'b1;
    pulse(0);
    clr_ctl();
    check("st_busy",  32'(busy_a), 1);
    check("st_we",    32'(mem_a.mem_we), 1);
    check("st_addr",  32'(mem_a.mem_addr), 'h80);
    check("st_wdata", 32'(mem_a.mem_wdata), 'h5A);
    src_sel = 2'd2; src_idx = 3'd0; mem_store = 1'b1; immediate = 1'b1;
    pulse(0);
    clr_ctl();
    check("st2_wdata", 32'(mem_a.mem_wdata), 'h5A);
    check("st2_addr",  32'(mem_a.mem_addr), 'h80);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    check("st_done_busy", 32'(busy_a), 0);
    check("st_done_req",  32'(mem_a.mem_req), 0);
    check("st_done_we",   32'(mem_a.mem_we), 0);
    check("st_writes",    32'(n_writes), 1);
    check("st_pc_hold",   32'(pc_a), 'h40);
    @(posedge clk); #1;
    check("st_noqueue", 32'(mem_a.mem_req), 0);

    // Store from the memory source drives zero
    clr_ctl();
    src_sel = 2'd0; mem_store = 1'b1;
    pulse(0);
    clr_ctl();
    check("stz_we",    32'(mem_a.mem_we), 1);
    check("stz_wdata", 32'(mem_a.mem_wdata), 0);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    check("stz_writes", 32'(n_writes), 2);

    // Reset in the middle of an access
    clr_ctl();
    src_sel = 2'd0; immediate = 1'b1; ir_load = 1'b1;
    pulse(0);
    clr_ctl();
    check("mid_busy", 32'(busy_a), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_req",   32'(mem_a.mem_req), 0);
    check("mid_rst_we",    32'(mem_a.mem_we), 0);
    check("mid_rst_busy",  32'(busy_a), 0);
    check("mid_rst_pc",    32'(pc_a), 0);
    check("mid_rst_ir",    32'(ir_a), 0);
    check("mid_rst_flag",  32'(flag_a), 0);
    check("mid_rst_azero", 32'(az_a), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    rdata = 16'h33; ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    ready = 1'b0;
    check("post_ir",   32'(ir_a), 0);
    check("post_pc",   32'(pc_a), 0);
    check("post_busy", 32'(busy_a), 0);
    check("post_req",  32'(mem_a.mem_req), 0);

    // 16-bit subtract: 2-1 sets carry, then 1-2 borrows
    load_reg(1, 3'd0, 16'h0002);
    load_reg(1, 3'd1, 16'h0001);
    clr_ctl();
    src_sel = 2'd1; do_subtract = 1'b1; dst_load = 1'b1; dst_idx = 3'd0; flag_load = 1'b1;
    pulse(1);
    check("sub1_flag", 32'(flag_b), 1);
    load_reg(1, 3'd1, 16'h0002);
    clr_ctl();
    src_sel = 2'd1; do_subtract = 1'b1; dst_load = 1'b1; dst_idx = 3'd0; flag_load = 1'b1;
    #1 check("sub2_dbus", 32'(dbus_b), 'hFFFF);
    pulse(1);
    check("sub2_flag", 32'(flag_b), 0);
    check("sub2_req",  32'(mem_b.mem_req), 0);
    clr_ctl();
    src_sel = 2'd2; src_idx = 3'd0;
    #1 check("sub2_reg0", 32'(dbus_b), 'hFFFF);
    check("sub2_azero", 32'(az_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_datapath.md
BUS_DATAPATH -- requirements
Module: bus_datapath

Interface
REQ-001 Parameter WIDTH, default 8, data/address width in bits (>=4).
REQ-002 Parameter NREGS, default 4, general registers (power of 2, >=2); IW = log2(NREGS).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 step  input  1  request execution of one micro-step using the control inputs below.
REQ-006 src_sel  input  2  dbus source: 0 memory, 1 ALU, 2 reg[src_idx], 3 zero.
REQ-007 src_idx  input  IW  source register index.
REQ-008 dst_load  input  1  load dbus into reg[dst_idx]; dst_idx input IW.
REQ-009 ir_load  input  1  load dbus into ir.
REQ-010 jump  input  1  load dbus into pc.
REQ-011 immediate  input  1  address = pc (else reg[NREGS-1]); pc increments on commit.
REQ-012 mem_store  input  1  write dbus to memory at the address.
REQ-013 do_subtract  input  1  ALU computes reg0-reg1 (else reg0+reg1).
REQ-014 flag_load  input  1  capture ALU carry into flag_carry on commit.
REQ-015 mem_req / mem_we  output  1 each  memory request / write qualifier.
REQ-016 mem_addr, mem_wdata  output  WIDTH  memory address, write data.
REQ-017 mem_rdata  input  WIDTH; mem_ready input 1  read data, request completion.
REQ-018 ir, pc  output  WIDTH  instruction register, program counter.
REQ-019 flag_carry, a_is_zero, busy  output  1 each  carry flag, reg0==0, access in progress.
REQ-020 dbus  output  WIDTH  current data-bus value, for monitoring.

Function
REQ-021 States IDLE and ACCESS; busy SHALL be 1 exactly in ACCESS.
REQ-022 In IDLE, step with src_sel!=0 and mem_store=0 SHALL commit in the same edge (zero-wait step).
REQ-023 In IDLE, step with src_sel=0 or mem_store=1 SHALL latch all controls and address, enter ACCESS, assert mem_req next cycle.
REQ-024 In ACCESS, mem_req SHALL stay high and latched controls stable until a cycle with mem_ready=1; commit occurs on that edge, state returns to IDLE, mem_req low next cycle.
REQ-025 step while busy SHALL be ignored; no queueing.
REQ-026 mem_we = mem_req and latched mem_store; mem_wdata = dbus; src_sel=0 with mem_store=1 SHALL drive zero on dbus (no read-modify).
REQ-027 Commit: registers selected by dst_load/ir_load/jump load dbus; flag_carry loads ALU carry when flag_load.
REQ-028 pc on commit: jump -> dbus (jump wins over increment); else immediate -> pc+1 mod 2^WIDTH; else hold.
REQ-029 ALU: WIDTH+1-bit sum; add carry = bit WIDTH; subtract = reg0 + ~reg1 + 1, carry=1 means no borrow.
REQ-030 dst_idx == src_idx SHALL load the pre-edge value (read-before-write).
REQ-031 a_is_zero combinational from reg0; dbus combinational from current (or latched) source.

Reset
REQ-032 reset SHALL immediately force state IDLE, mem_req=0, mem_we=0, pc=0, ir=0, all regs=0, flag_carry=0; busy=0, a_is_zero=1.
REQ-033 reset during ACCESS SHALL abandon the access; a later mem_ready SHALL be ignored until a new request.

Structure
REQ-034 Shared package holds src_sel encodings and state enumeration.
REQ-035 One sub-module bus_alu (add/sub, carry, zero) is instantiated; register file is inline.

Verification
REQ-036 WIDTH=8: reg0=0xF0, reg1=0x20, step src_sel=1 dst_load idx0 flag_load -> reg0=0x10, flag_carry=1, no mem_req.
REQ-037 pc=0x05, step src_sel=0 immediate ir_load, mem_ready after 3 cycles with 0xA7 -> busy 3 cycles, ir=0xA7, pc=0x06.
REQ-038 pc=0xFF, immediate zero-wait step -> pc=0x00; same with jump, dbus=0x40 -> pc=0x40.
REQ-039 mem_store from reg2=0x5A, addr reg3=0x80, step pulsed again while busy -> one write, mem_we=1, addr 0x80, data 0x5A; second step ignored.
REQ-040 reset asserted mid-ACCESS, then mem_ready -> mem_req drops immediately, all outputs at reset values, no commit.
REQ-041 WIDTH=16, NREGS=8: subtract 0x0001-0x0002 -> reg0=0xFFFF, flag_carry=0.
